lockstep_stage_checker: RTL and testbench

//  Synthesizable lockstep scoreboard comparing DUT vs golden-model values on NUM_CH pipeline-stage channels
//  (default IF/ID/EX/MEM/WB). Per-channel alignment FIFOs absorb DUT/model latency skew. Tracks mismatches,

---
 rtl/lockstep_stage_checker.sv | 201 ++++++++++++++++++++
 tb/tb_lockstep_stage_checker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lockstep_stage_checker.sv
// lockstep_stage_checker: DUT-vs-model lockstep scoreboard; define LOCKSTEP_PERCH_CNT_EN to add per-channel mismatch counters (mm_cnt_ch)
module lockstep_stage_checker #(
    parameter int NUM_CH       = 5,
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic [NUM_CH-1:0]           dut_valid,
    input  logic [NUM_CH*WIDTH-1:0]     dut_data,
    input  logic [NUM_CH-1:0]           ref_valid,
    input  logic [NUM_CH*WIDTH-1:0]     ref_data,
    input  logic                        hlt,
    output logic                        done,
    output logic                        pass,
    output logic                        err,
    output logic                        ovf,
    output logic                        leftover,
    output logic [CNT_W-1:0]            mm_cnt,
    output logic [$clog2(NUM_CH)-1:0]   first_ch,
    output logic [CNT_W-1:0]            first_seq,
    output logic [WIDTH-1:0]            first_dut,
    output logic [WIDTH-1:0]            first_ref
`ifdef LOCKSTEP_PERCH_CNT_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]     mm_cnt_ch
`endif
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(NUM_CH);
    localparam int PCW = $clog2(NUM_CH + 1);
    localparam int SW  = CNT_W + PCW;
    localparam int DW  = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, CHECK, DONE} state_t;
    state_t state, state_nx;
    logic [DW-1:0] cnt;

    logic [WIDTH-1:0] dmem [NUM_CH][DEPTH];
    logic [WIDTH-1:0] rmem [NUM_CH][DEPTH];
    logic [PW:0] dwp [NUM_CH];
    logic [PW:0] drp [NUM_CH];
    logic [PW:0] rwp [NUM_CH];
    logic [PW:0] rrp [NUM_CH];
    logic [WIDTH-1:0] dhead [NUM_CH];
    logic [WIDTH-1:0] rhead [NUM_CH];
    logic [CNT_W-1:0] seq [NUM_CH];
    logic [NUM_CH-1:0] dne, rne, dfull, rfull, dpush, rpush, cmp, mm_vec, mm_r;
    logic active, ovf_evt, left_evt;
    logic [CW-1:0] sel_ch, sel_ch_r;
    logic [CNT_W-1:0] sel_seq, sel_seq_r;
    logic [WIDTH-1:0] sel_d, sel_r, sel_d_r, sel_r_r;
    logic [PCW-1:0] pc;
    logic [SW-1:0] sum;
    logic [CNT_W-1:0] mm_nx;

    assign active = state == RUN || state == DRAIN;

    always_comb begin
        dhead = '{default: '0};
        rhead = '{default: '0};
        dne = '0;
        rne = '0;
        dfull = '0;
        rfull = '0;
        cmp = '0;
        mm_vec = '0;
        dpush = '0;
        rpush = '0;
        ovf_evt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            dhead[i] = dmem[i][drp[i][PW-1:0]];
            rhead[i] = rmem[i][rrp[i][PW-1:0]];
            dne[i] = dwp[i] != drp[i];
            rne[i] = rwp[i] != rrp[i];
            dfull[i] = (dwp[i] ^ drp[i]) == {1'b1, {PW{1'b0}}};
            rfull[i] = (rwp[i] ^ rrp[i]) == {1'b1, {PW{1'b0}}};
            cmp[i] = active && ch_en[i] && dne[i] && rne[i];
            mm_vec[i] = cmp[i] && dhead[i] != rhead[i];
            dpush[i] = active && ch_en[i] && dut_valid[i] && (!dfull[i] || cmp[i]);
            rpush[i] = active && ch_en[i] && ref_valid[i] && (!rfull[i] || cmp[i]);
            ovf_evt = ovf_evt || (active && ch_en[i] && !cmp[i] &&
                                  ((dut_valid[i] && dfull[i]) || (ref_valid[i] && rfull[i])));
        end
        left_evt = state == CHECK && |(ch_en & (dne | rne));
    end

    // scan high to low so the lowest mismatching channel is the one kept
    always_comb begin
        sel_ch = '0;
        sel_seq = '0;
        sel_d = '0;
        sel_r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (mm_vec[i]) begin
                sel_ch = CW'(i);
                sel_seq = seq[i];
                sel_d = dhead[i];
                sel_r = rhead[i];
            end
    end

    always_comb begin
        pc = '0;
        for (int i = 0; i < NUM_CH; i++)
            pc = pc + PCW'(mm_r[i]);
    end

    assign sum = SW'(mm_cnt) + SW'(pc);
    assign mm_nx = sum > SW'({CNT_W{1'b1}}) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    always_ff @(posedge clk)
        for (int i = 0; i < NUM_CH; i++) begin
            if (dpush[i]) dmem[i][dwp[i][PW-1:0]] <= dut_data[i*WIDTH +: WIDTH];
            if (rpush[i]) rmem[i][rwp[i][PW-1:0]] <= ref_data[i*WIDTH +: WIDTH];
        end

    always_ff @(posedge clk)
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                dwp[i] <= '0;
                drp[i] <= '0;
                rwp[i] <= '0;
                rrp[i] <= '0;
                seq[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (dpush[i]) dwp[i] <= dwp[i] + (PW+1)'(1);
                if (rpush[i]) rwp[i] <= rwp[i] + (PW+1)'(1);
                if (cmp[i]) begin
                    drp[i] <= drp[i] + (PW+1)'(1);
                    rrp[i] <= rrp[i] + (PW+1)'(1);
                    seq[i] <= seq[i] + CNT_W'(1);
                end
            end
        end

    always_ff @(posedge clk)
        if (rst) begin
            mm_r <= '0;
            sel_ch_r <= '0;
            sel_seq_r <= '0;
            sel_d_r <= '0;
            sel_r_r <= '0;
            err <= 1'b0;
            ovf <= 1'b0;
            leftover <= 1'b0;
            mm_cnt <= '0;
            first_ch <= '0;
            first_seq <= '0;
            first_dut <= '0;
            first_ref <= '0;
        end else begin
            mm_r <= mm_vec;
            sel_ch_r <= sel_ch;
            sel_seq_r <= sel_seq;
            sel_d_r <= sel_d;
            sel_r_r <= sel_r;
            if (ovf_evt) ovf <= 1'b1;
            if (left_evt) leftover <= 1'b1;
            err <= err || ovf_evt || left_evt || |mm_r;
            mm_cnt <= mm_nx;
            if (!err && |mm_r) begin
                first_ch <= sel_ch_r;
                first_seq <= sel_seq_r;
                first_dut <= sel_d_r;
                first_ref <= sel_r_r;
            end
        end

`ifdef LOCKSTEP_PERCH_CNT_EN
    always_ff @(posedge clk)
        if (rst) mm_cnt_ch <= '0;
        else
            for (int i = 0; i < NUM_CH; i++)
                if (mm_r[i] && !(&mm_cnt_ch[i*CNT_W +: CNT_W]))
                    mm_cnt_ch[i*CNT_W +: CNT_W] <= mm_cnt_ch[i*CNT_W +: CNT_W] + CNT_W'(1);
`endif

    always_ff @(posedge clk)
        if (rst) begin
            state <= RUN;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= state == RUN ? DW'(DRAIN_CYCLES - 1) : state == DRAIN ? cnt - DW'(1) : cnt;
        end

    always_comb
        state_nx = state == RUN   ? (hlt ? DRAIN : RUN) :
                   state == DRAIN ? (cnt == '0 ? CHECK : DRAIN) : DONE;

    always_comb begin
        done = state == DONE;
        pass = done && !err;
    end
endmodule

// File: tb/tb_lockstep_stage_checker.sv
// tb_lockstep_stage_checker: randomized and directed lockstep runs scored against a queue-based reference model
module tb_lockstep_stage_checker;
    localparam int NC = 5, W = 16, D = 4, DR = 3, MAXC = 200;

    logic clk = 1'b0;
    logic rst, hlt;
    logic [NC-1:0] ch_en, dut_valid, ref_valid;
    logic [NC*W-1:0] dut_data, ref_data;
    logic done, pass, err, ovf, leftover;
    logic [15:0] mm_cnt, first_seq, first_dut, first_ref;
    logic [2:0] first_ch;
    logic done4, pass4, err4, ovf4, left4;
    logic [3:0] mm_cnt4, first_seq4;
    logic [2:0] first_ch4;
    logic [15:0] first_dut4, first_ref4;
`ifdef LOCKSTEP_PERCH_CNT_EN
    logic [NC*16-1:0] mm_cnt_ch;
    logic [NC*4-1:0] mm_cnt_ch4;
`endif

    lockstep_stage_checker dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .dut_valid(dut_valid), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_data(ref_data), .hlt(hlt), .done(done), .pass(pass),
        .err(err), .ovf(ovf), .leftover(leftover), .mm_cnt(mm_cnt), .first_ch(first_ch),
        .first_seq(first_seq), .first_dut(first_dut), .first_ref(first_ref)
`ifdef LOCKSTEP_PERCH_CNT_EN
        , .mm_cnt_ch(mm_cnt_ch)
`endif
    );

    lockstep_stage_checker #(.CNT_W(4)) u4 (
        .clk(clk), .rst(rst), .ch_en(ch_en), .dut_valid(dut_valid), .dut_data(dut_data),
        .ref_valid(ref_valid), .ref_data(ref_data), .hlt(hlt), .done(done4), .pass(pass4),
        .err(err4), .ovf(ovf4), .leftover(left4), .mm_cnt(mm_cnt4), .first_ch(first_ch4),
        .first_seq(first_seq4), .first_dut(first_dut4), .first_ref(first_ref4)
`ifdef LOCKSTEP_PERCH_CNT_EN
        , .mm_cnt_ch(mm_cnt_ch4)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit snap;
        bit pass, err, ovf, leftover;
        int mm, mm4, fch, fseq, fseq4, dcyc;
        logic [W-1:0] fd, fr;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int vectors = 0, miscompares = 0;
    int edge_n = 0, t0 = 0;
    bit snap = 0, done_q = 0;

    logic sdv [NC][MAXC];
    logic srv [NC][MAXC];
    logic [W-1:0] sdd [NC][MAXC];
    logic [W-1:0] srd [NC][MAXC];
    logic [W-1:0] mdq [NC][$];
    logic [W-1:0] mrq [NC][$];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string n, input longint a, input longint x);
        vectors++;
        if (a != x) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, x);
        end
    endtask

    always @(negedge clk) begin
        if (snap || (done && !done_q)) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard: output event with no expected entry");
            end else begin
                me = q.pop_front();
                if (me.snap) begin
                    chk("done", longint'(done), 0);
                    chk("done4", longint'(done4), 0);
                end else chk("done_cycle", longint'(edge_n - t0 - 1), longint'(me.dcyc));
                chk("pass", longint'(pass), longint'(me.pass));
                chk("err", longint'(err), longint'(me.err));
                chk("ovf", longint'(ovf), longint'(me.ovf));
                chk("leftover", longint'(leftover), longint'(me.leftover));
                chk("mm_cnt", longint'(mm_cnt), longint'(me.mm));
                chk("first_ch", longint'(first_ch), longint'(me.fch));
                chk("first_seq", longint'(first_seq), longint'(me.fseq));
                chk("first_dut", longint'(first_dut), longint'(me.fd));
                chk("first_ref", longint'(first_ref), longint'(me.fr));
                chk("pass4", longint'(pass4), longint'(me.pass));
                chk("mm_cnt4", longint'(mm_cnt4), longint'(me.mm4));
                chk("first_seq4", longint'(first_seq4), longint'(me.fseq4));
                chk("first_ch4", longint'(first_ch4), longint'(me.fch));
                chk("err4", longint'(err4), longint'(me.err));
                chk("ovf4", longint'(ovf4), longint'(me.ovf));
                chk("leftover4", longint'(left4), longint'(me.leftover));
                chk("first_dut4", longint'(first_dut4), longint'(me.fd));
                chk("first_ref4", longint'(first_ref4), longint'(me.fr));
            end
        end
        done_q = done;
    end

    // Spec-level model: two FIFOs per channel as queues, a pair compares in the cycle both heads exist.
    task automatic model(input logic [NC-1:0] en, input int H, output exp_t e);
        int ovf_c, mm;
        int seqn [NC];
        bit pf [NC];
        bit found;
        logic [W-1:0] a, b;
        e = '{default: 0};
        ovf_c = 1 << 30;
        mm = 0;
        found = 0;
        for (int c = 0; c < NC; c++) begin
            mdq[c].delete();
            mrq[c].delete();
            seqn[c] = 0;
        end
        for (int t = 0; t <= H + DR; t++) begin
            for (int c = 0; c < NC; c++)
                pf[c] = en[c] && mdq[c].size() > 0 && mrq[c].size() > 0;
            for (int c = 0; c < NC; c++) begin
                if (en[c] && sdv[c][t]) begin
                    if (mdq[c].size() < D || pf[c]) mdq[c].push_back(sdd[c][t]);
                    else if (ovf_c > t) ovf_c = t;
                end
                if (en[c] && srv[c][t]) begin
                    if (mrq[c].size() < D || pf[c]) mrq[c].push_back(srd[c][t]);
                    else if (ovf_c > t) ovf_c = t;
                end
            end
            for (int c = 0; c < NC; c++)
                if (pf[c]) begin
                    a = mdq[c].pop_front();
                    b = mrq[c].pop_front();
                    if (a != b) begin
                        mm++;
                        if (!found && ovf_c > t) begin
                            e.fch = c;
                            e.fseq = seqn[c];
                            e.fd = a;
                            e.fr = b;
                        end
                        found = 1;
                    end
                    seqn[c]++;
                end
        end
        for (int c = 0; c < NC; c++)
            if (en[c] && (mdq[c].size() > 0 || mrq[c].size() > 0)) e.leftover = 1;
        e.ovf = ovf_c < (1 << 30);
        e.err = e.ovf || e.leftover || mm > 0;
        e.pass = !e.err;
        e.mm = mm > 65535 ? 65535 : mm;
        e.mm4 = mm > 15 ? 15 : mm;
        e.fseq4 = e.fseq % 16;
        e.dcyc = H + DR + 1;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < NC; c++)
            for (int t = 0; t < MAXC; t++) begin
                sdv[c][t] = 0;
                srv[c][t] = 0;
                sdd[c][t] = '0;
                srd[c][t] = '0;
            end
    endtask

    task automatic set_d(input int c, input int t, input logic [W-1:0] v);
        sdv[c][t] = 1;
        sdd[c][t] = v;
    endtask

    task automatic set_r(input int c, input int t, input logic [W-1:0] v);
        srv[c][t] = 1;
        srd[c][t] = v;
    endtask

    task automatic matched(input int n);
        logic [W-1:0] v;
        for (int c = 0; c < NC; c++)
            for (int k = 0; k < n; k++) begin
                v = W'($urandom);
                set_d(c, k, v);
                set_r(c, k, v);
            end
    endtask

    task automatic snap_check();
        exp_t e;
        e = '{default: 0};
        e.snap = 1;
        q.push_back(e);
        snap = 1;
        @(negedge clk);
        #1 snap = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        hlt = 0;
        dut_valid = '0;
        ref_valid = '0;
        @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic run(input logic [NC-1:0] en, input int H, input bit abort);
        exp_t e;
        bit seen;
        if (!abort) begin
            model(en, H, e);
            q.push_back(e);
        end
        ch_en = en;
        t0 = edge_n;
        for (int c = 0; c <= H + DR; c++) begin
            for (int i = 0; i < NC; i++) begin
                dut_valid[i] = sdv[i][c];
                dut_data[i*W +: W] = sdd[i][c];
                ref_valid[i] = srv[i][c];
                ref_data[i*W +: W] = srd[i][c];
            end
            hlt = c >= H;
            @(posedge clk);
            #1;
            if (abort && c == H + 1) break;
        end
        dut_valid = '0;
        ref_valid = '0;
        if (abort) begin
            rst = 1;
            @(posedge clk);
            #1 snap_check();
        end else begin
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(posedge clk);
                #1 seen = done;
            end
            if (!seen) begin
                vectors++;
                miscompares++;
                $display("FAIL done_timeout: done=0 after bound, expected 1");
                void'(q.pop_back());
            end
            repeat (2) @(posedge clk);
            #1;
        end
        do_reset();
    endtask

    task automatic gen_rand(output int H);
        int td, tr;
        logic [W-1:0] v;
        clear_sched();
        H = 0;
        for (int c = 0; c < NC; c++) begin
            td = $urandom_range(0, 3);
            tr = $urandom_range(0, 3);
            for (int k = 0; k < 30; k++) begin
                v = W'($urandom);
                set_d(c, td, v);
                set_r(c, tr, ($urandom_range(0, 15) == 0) ? v ^ W'(1 << $urandom_range(0, W - 1)) : v);
                td += 1 + $urandom_range(0, 1);
                tr += 1 + $urandom_range(0, 1);
            end
            H = td > H ? td : H;
            H = tr > H ? tr : H;
        end
        H += $urandom_range(0, 2);
    endtask

    initial begin
        int H;
        logic [W-1:0] v;
        rst = 1;
        hlt = 0;
        ch_en = '1;
        dut_valid = '0;
        ref_valid = '0;
        dut_data = '0;
        ref_data = '0;
        repeat (3) @(posedge clk);
        #1 snap_check();
        rst = 0;

        clear_sched();
        matched(100);
        run('1, 120, 0);

        clear_sched();
        matched(30);
        set_d(2, 7, 16'h1234);
        set_r(2, 7, 16'h1235);
        set_d(4, 7, 16'h00ff);
        set_r(4, 7, 16'hff00);
        run('1, 40, 0);

        clear_sched();
        for (int k = 0; k < 20; k++) begin
            v = W'($urandom);
            set_r(0, k, v);
            set_d(0, k + 3, v);
        end
        run('1, 30, 0);

        clear_sched();
        for (int k = 0; k < 5; k++) begin
            v = W'($urandom);
            set_r(0, k, v);
            if (k < 4) set_d(0, 5 + k, v);
        end
        run('1, 15, 0);

        clear_sched();
        matched(10);
        set_d(1, 10, 16'hbeef);
        run('1, 20, 0);

        clear_sched();
        matched(25);
        for (int k = 2; k < 22; k++) set_r(3, k, sdd[3][k] ^ 16'h0001);
        run('1, 35, 0);

        clear_sched();
        matched(30);
        set_r(2, 7, 16'h1235);
        run('1, 40, 1);

        clear_sched();
        matched(30);
        for (int k = 0; k < 30; k++) set_r(2, k, W'($urandom));
        set_d(2, 31, 16'hdead);
        run(5'b11011, 40, 0);

        for (int r = 0; r < 4; r++) begin
            gen_rand(H);
            run(r == 3 ? (NC'($urandom) | NC'(1)) : '1, H, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
